// File: rtl/octal_entry.sv
// Octal operand entry for the RPN ALU: debounced push-buttons assemble an 8-bit
// value three bits at a time and offer it to the stack via VALID/ACK.
module octal_entry #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] DIGIT_SW,
  input  logic       KEY_DIGIT,
  input  logic       KEY_CLEAR,
  input  logic       KEY_ENTER,
  input  logic       ACK,
  output logic [7:0] OPERAND,
  output logic [1:0] DIGIT_CNT,
  output logic       VALID,
  output logic       OVF
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  localparam logic ENTRY = 1'b0;
  localparam logic HOLD  = 1'b1;

  // Key lanes: bit 0 = DIGIT, bit 1 = CLEAR, bit 2 = ENTER.
  logic [2:0]    key_raw;
  logic [2:0]    key_s1;
  logic [2:0]    key_s2;
  logic [2:0]    deb;
  logic [2:0]    deb_d;
  logic [2:0]    evt;
  logic [CW-1:0] cnt [3];
  logic [2:0]    sw_s1;
  logic [2:0]    sw_s2;
  logic          state;

  assign key_raw = {KEY_ENTER, KEY_CLEAR, KEY_DIGIT};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      key_s1 <= '1;
      key_s2 <= '1;
      deb    <= '1;
      deb_d  <= '1;
      evt    <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      key_s1 <= key_raw;
      key_s2 <= key_s1;
      sw_s1  <= DIGIT_SW;
      sw_s2  <= sw_s1;
      deb_d  <= deb;
      // Registered falling edge of the debounced level; lands one edge after the flip.
      evt    <= deb_d & ~deb;
      for (int unsigned i = 0; i < 3; i++) begin
        if (key_s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= key_s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ENTRY;
      OPERAND   <= '0;
      DIGIT_CNT <= '0;
      OVF       <= 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          if (evt[1]) begin
            OPERAND   <= '0;
            DIGIT_CNT <= '0;
            OVF       <= 1'b0;
          end else if (evt[2]) begin
            if (DIGIT_CNT != 2'd0) state <= HOLD;
          end else if (evt[0]) begin
            if (DIGIT_CNT != 2'd3 && OPERAND[7:5] == 3'd0) begin
              OPERAND   <= {OPERAND[4:0], sw_s2};
              DIGIT_CNT <= DIGIT_CNT + 2'd1;
            end else begin
              OVF <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (evt[1] || ACK) begin
            state     <= ENTRY;
            OPERAND   <= '0;
            DIGIT_CNT <= '0;
            OVF       <= 1'b0;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

  assign VALID = state;

endmodule

// File: tb/tb_octal_entry.sv
// Self-checking bench for octal_entry: vector table, directed timing sequences,
// and randomized key operations against a value-level reference model.
module tb_octal_entry;

  localparam int DEB = 4;
  localparam int OP_DIGIT = 0;
  localparam int OP_CLEAR = 1;
  localparam int OP_ENTER = 2;
  localparam int OP_ACK   = 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] DIGIT_SW = 3'd0;
  logic       KEY_DIGIT = 1'b1;
  logic       KEY_CLEAR = 1'b1;
  logic       KEY_ENTER = 1'b1;
  logic       ACK = 1'b0;
  logic [7:0] OPERAND;
  logic [1:0] DIGIT_CNT;
  logic       VALID;
  logic       OVF;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_val = 0;
  int m_cnt = 0;
  int m_valid = 0;
  int m_ovf = 0;

  octal_entry #(.DEB_CYCLES(DEB)) dut (
    .CLK(CLK), .RST_N(RST_N), .DIGIT_SW(DIGIT_SW),
    .KEY_DIGIT(KEY_DIGIT), .KEY_CLEAR(KEY_CLEAR), .KEY_ENTER(KEY_ENTER),
    .ACK(ACK), .OPERAND(OPERAND), .DIGIT_CNT(DIGIT_CNT), .VALID(VALID), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int op;
    int d;
    int e_val;
    int e_cnt;
    int e_valid;
    int e_ovf;
  } vec_t;

  vec_t tbl [21];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int v, input int c, input int vl, input int o);
    check({tag, ".operand"}, int'(OPERAND), v);
    check({tag, ".digit_cnt"}, int'(DIGIT_CNT), c);
    check({tag, ".valid"}, int'(VALID), vl);
    check({tag, ".ovf"}, int'(OVF), o);
  endtask

  task automatic check_model(input string tag);
    check_all(tag, m_val, m_cnt, m_valid, m_ovf);
  endtask

  task automatic set_key(input int op, input logic lvl);
    case (op)
      OP_DIGIT: KEY_DIGIT = lvl;
      OP_CLEAR: KEY_CLEAR = lvl;
      default:  KEY_ENTER = lvl;
    endcase
  endtask

  task automatic model_apply(input int op, input int d);
    case (op)
      OP_CLEAR: begin m_val = 0; m_cnt = 0; m_ovf = 0; m_valid = 0; end
      OP_ENTER: if (m_valid == 0 && m_cnt != 0) m_valid = 1;
      OP_ACK:   if (m_valid == 1) begin m_val = 0; m_cnt = 0; m_ovf = 0; m_valid = 0; end
      default:  if (m_valid == 0) begin
                  if (m_cnt < 3 && m_val * 8 + d < 256) begin
                    m_val = m_val * 8 + d;
                    m_cnt = m_cnt + 1;
                  end else begin
                    m_ovf = 1;
                  end
                end
    endcase
  endtask

  task automatic do_op(input int op, input int d);
    if (op == OP_ACK) begin
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
      tick();
    end else begin
      DIGIT_SW = d[2:0];
      tick();
      tick();
      set_key(op, 1'b0);
      repeat (DEB + 3) tick();
      set_key(op, 1'b1);
      repeat (DEB + 4) tick();
    end
  endtask

  initial begin
    tbl[0]  = '{OP_DIGIT, 3, 3, 1, 0, 0};
    tbl[1]  = '{OP_DIGIT, 7, 31, 2, 0, 0};
    tbl[2]  = '{OP_DIGIT, 7, 255, 3, 0, 0};
    tbl[3]  = '{OP_ENTER, 0, 255, 3, 1, 0};
    tbl[4]  = '{OP_ACK,   0, 0, 0, 0, 0};
    tbl[5]  = '{OP_DIGIT, 4, 4, 1, 0, 0};
    tbl[6]  = '{OP_DIGIT, 0, 32, 2, 0, 0};
    tbl[7]  = '{OP_DIGIT, 0, 32, 2, 0, 1};
    tbl[8]  = '{OP_CLEAR, 0, 0, 0, 0, 0};
    tbl[9]  = '{OP_DIGIT, 1, 1, 1, 0, 0};
    tbl[10] = '{OP_DIGIT, 2, 10, 2, 0, 0};
    tbl[11] = '{OP_DIGIT, 3, 83, 3, 0, 0};
    tbl[12] = '{OP_DIGIT, 5, 83, 3, 0, 1};
    tbl[13] = '{OP_CLEAR, 0, 0, 0, 0, 0};
    tbl[14] = '{OP_ENTER, 0, 0, 0, 0, 0};
    tbl[15] = '{OP_DIGIT, 5, 5, 1, 0, 0};
    tbl[16] = '{OP_DIGIT, 2, 42, 2, 0, 0};
    tbl[17] = '{OP_ENTER, 0, 42, 2, 1, 0};
    tbl[18] = '{OP_DIGIT, 1, 42, 2, 1, 0};
    tbl[19] = '{OP_CLEAR, 0, 0, 0, 0, 0};
    tbl[20] = '{OP_ACK,   0, 0, 0, 0, 0};

    // Reset and idle
    RST_N = 1'b0;
    repeat (3) tick();
    check_all("reset", 0, 0, 0, 0);
    RST_N = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle", int'({OPERAND, DIGIT_CNT, VALID, OVF}), 0);
    end

    // Vector table
    for (int i = 0; i < 21; i++) begin
      do_op(tbl[i].op, tbl[i].d);
      check_all($sformatf("vec%0d", i), tbl[i].e_val, tbl[i].e_cnt, tbl[i].e_valid, tbl[i].e_ovf);
    end

    // Press latency and same-edge ACK
    do_op(OP_DIGIT, 6);
    KEY_ENTER = 1'b0;
    repeat (DEB + 3) tick();
    check("lat.before", int'(VALID), 0);
    tick();
    check("lat.edge", int'(VALID), 1);
    repeat (4) tick();
    KEY_ENTER = 1'b1;
    repeat (DEB + 4) tick();
    ACK = 1'b1;
    tick();
    check("ack.valid", int'(VALID), 0);
    check("ack.operand", int'(OPERAND), 0);
    repeat (3) tick();
    ACK = 1'b0;
    tick();
    check_all("ack.held", 0, 0, 0, 0);

    // Bounce rejection, then a clean long press
    DIGIT_SW = 3'd6;
    tick(); tick();
    KEY_DIGIT = 1'b0; repeat (3) tick();
    KEY_DIGIT = 1'b1; tick();
    KEY_DIGIT = 1'b0; repeat (3) tick();
    KEY_DIGIT = 1'b1; repeat (DEB + 6) tick();
    check_all("bounce", 0, 0, 0, 0);
    KEY_DIGIT = 1'b0; repeat (10) tick();
    KEY_DIGIT = 1'b1; repeat (DEB + 4) tick();
    check_all("longpress", 6, 1, 0, 0);

    // Coincident CLEAR and DIGIT
    do_op(OP_CLEAR, 0);
    do_op(OP_DIGIT, 0);
    do_op(OP_DIGIT, 5);
    check_all("prio.pre", 5, 2, 0, 0);
    DIGIT_SW = 3'd1;
    tick(); tick();
    KEY_CLEAR = 1'b0;
    KEY_DIGIT = 1'b0;
    repeat (DEB + 3) tick();
    KEY_CLEAR = 1'b1;
    KEY_DIGIT = 1'b1;
    repeat (DEB + 4) tick();
    check_all("prio", 0, 0, 0, 0);

    // Mid-HOLD reset, then a stray ACK
    do_op(OP_DIGIT, 5);
    do_op(OP_DIGIT, 2);
    do_op(OP_ENTER, 0);
    check_all("hold.pre", 42, 2, 1, 0);
    RST_N = 1'b0;
    tick();
    check("rst.valid", int'(VALID), 0);
    RST_N = 1'b1;
    tick();
    do_op(OP_ACK, 0);
    check_all("rst.ack", 0, 0, 0, 0);

    // Key held low across reset yields one fresh event
    DIGIT_SW = 3'd3;
    tick(); tick();
    KEY_DIGIT = 1'b0;
    repeat (DEB + 6) tick();
    RST_N = 1'b0;
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (DEB + 6) tick();
    check_all("heldrst", 3, 1, 0, 0);
    KEY_DIGIT = 1'b1;
    repeat (DEB + 6) tick();
    check_all("heldrst.rel", 3, 1, 0, 0);

    // Randomized operations against the model
    do_op(OP_CLEAR, 0);
    m_val = 0; m_cnt = 0; m_valid = 0; m_ovf = 0;
    for (int i = 0; i < 80; i++) begin
      int r;
      int d;
      r = int'($urandom_range(0, 9));
      d = int'($urandom_range(0, 7));
      if (r <= 4) begin
        do_op(OP_DIGIT, d);
        model_apply(OP_DIGIT, d);
      end else if (r == 5) begin
        do_op(OP_CLEAR, 0);
        model_apply(OP_CLEAR, 0);
      end else if (r <= 7) begin
        do_op(OP_ENTER, 0);
        model_apply(OP_ENTER, 0);
      end else if (r == 8) begin
        do_op(OP_ACK, 0);
        model_apply(OP_ACK, 0);
      end else begin
        int k;
        int g;
        k = int'($urandom_range(0, 2));
        g = int'($urandom_range(1, DEB - 1));
        set_key(k, 1'b0);
        repeat (g) tick();
        set_key(k, 1'b1);
        repeat (DEB + 4) tick();
      end
      check_model($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/octal_entry.md
# octal_entry

Operand-entry front end for the 8-bit RPN ALU: turns three raw push-buttons plus a 3-bit octal digit switch bank into a debounced, octal-assembled 8-bit operand. Offers the operand to the RPN stack through a VALID/ACK handshake. It is the input-side counterpart of the octal seven-segment display path, which renders the same 3-bit digits on the output side.

## Interface
- DEB_CYCLES, 4: consecutive stable synchronized samples required to accept a key level change (≥1; board builds override to ~500000).
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  synchronous reset, active-low.
- DIGIT_SW  in  3  octal digit to append (static switches, 2-flop synchronized).
- KEY_DIGIT  in  1  raw button, active-low: append DIGIT_SW.
- KEY_CLEAR  in  1  raw button, active-low: discard entry.
- KEY_ENTER  in  1  raw button, active-low: offer operand.
- ACK  in  1  stack consumed operand (sampled only while VALID=1).
- OPERAND  out  8  current assembled value.
- DIGIT_CNT  out  2  digits accepted so far (0–3).
- VALID  out  1  operand offered, held until ACK.
- OVF  out  1  sticky: a digit was rejected.

## Operation
- Key path, per key: 2-flop synchronizer → debouncer (counter resets whenever the synchronized sample equals the debounced level; the debounced level flips when the counter reaches DEB_CYCLES) → press detector emitting a 1-cycle registered event on the debounced 1→0 transition. Releases produce no event.
- FSM states: ENTRY, HOLD.
- ENTRY, event priority when several events occur in the same cycle: CLEAR > ENTER > DIGIT.
  - CLEAR: OPERAND=0, DIGIT_CNT=0, OVF=0.
  - ENTER: if DIGIT_CNT≠0 → HOLD, VALID=1. If DIGIT_CNT=0, ignored.
  - DIGIT: accepted iff DIGIT_CNT<3 and OPERAND[7:5]=0. On accept, OPERAND={OPERAND[4:0],DIGIT_SW} and DIGIT_CNT+1. On reject, OPERAND and DIGIT_CNT are unchanged and OVF=1. Maximum representable value is 377₈=255.
- HOLD: OPERAND and DIGIT_CNT frozen; DIGIT and ENTER events are dropped.
  - ACK=1 → ENTRY, VALID=0, OPERAND=0, DIGIT_CNT=0, OVF=0.
  - CLEAR event → same as ACK (abort). CLEAR has priority if coincident with ACK; the result is identical either way.
- ACK while VALID=0 is ignored.

## Timing
- Reset values: OPERAND=0, DIGIT_CNT=0, VALID=0, OVF=0, state ENTRY, synchronizers and debounced levels=1 (released), counters=0.
- Reset is synchronous and takes effect at the first CLK edge with RST_N=0, including mid-HOLD (VALID falls at that edge).
- A key held low across reset debounces as a fresh press and yields one event after reset is released.
- Press latency: raw key low, first sampled at edge 1 → OPERAND/VALID updated at edge DEB_CYCLES+4. This covers 2 sync edges, DEB_CYCLES count edges, 1 event-register edge and 1 datapath edge.
- Any low pulse shorter than DEB_CYCLES synchronized samples produces no event.
- DIGIT_SW is sampled (synchronized copy) in the same cycle the DIGIT event is processed.
- VALID rises at the same edge the ENTER event is processed.
- ACK is seen at edge N → VALID=0 and OPERAND=0 at edge N. Single-cycle ACK is sufficient; holding ACK longer has no further effect.
- No combinational path from any input to any output.

## Test plan
- Reset: RST_N=0 for 3 cycles with all keys high → OPERAND=0x00, DIGIT_CNT=0, VALID=0, OVF=0; no events for 50 cycles after release.
- Entry and handshake (DEB_CYCLES=4): digits 3,7,7 → OPERAND=0xFF, DIGIT_CNT=3. ENTER → VALID=1 at edge DEB_CYCLES+4 after the press. ACK pulse → VALID=0, OPERAND=0x00 at the same edge.
- Overflow: digits 4,0 → OPERAND=0x20, DIGIT_CNT=2. Digit 0 → OPERAND stays 0x20, OVF=1. Separately, after 1,2,3 (0x53), a fourth digit → rejected, OVF=1. CLEAR → OVF=0.
- Bounce: KEY_DIGIT low 3 cycles, high 1, low 3 (DEB_CYCLES=4) → no change. Then held low 10 cycles → exactly one digit accepted.
- Priority: CLEAR and DIGIT events in the same cycle with OPERAND=0x05 → OPERAND=0x00, DIGIT_CNT=0. ENTER with DIGIT_CNT=0 → VALID stays 0.
- Abort and mid-HOLD reset: in HOLD with 0x2A, digit press → OPERAND stays 0x2A. CLEAR → VALID=0, OPERAND=0. Re-enter 0x2A, ENTER, then RST_N=0 for one edge → VALID=0 at that edge; a later ACK is ignored.
